// File: rtl/crack_pkg.sv
// rtl/crack_pkg.sv - shared types and constants for the N-core ARC4 key-search dispatcher
package crack_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } dispatch_state_t;

    localparam int KEY_W_DEFAULT = 24;
    localparam int NCORES_MAX    = 16;

endpackage

// File: rtl/crack_dispatch_if.sv
// rtl/crack_dispatch_if.sv - dispatcher-to-core-array bus; master is the dispatcher side
interface crack_dispatch_if #(
    parameter int NCORES = 2,
    parameter int KEY_W  = 24
);

    logic [NCORES-1:0]       core_en;
    logic [NCORES-1:0]       core_rdy;
    logic [NCORES*KEY_W-1:0] core_start;
    logic [KEY_W-1:0]        core_stride;
    logic                    core_abort;
    logic [NCORES-1:0]       core_done;
    logic [NCORES-1:0]       core_found;
    logic [NCORES*KEY_W-1:0] core_key;

    modport master (
        output core_en, core_start, core_stride, core_abort,
        input  core_rdy, core_done, core_found, core_key
    );

    modport slave (
        input  core_en, core_start, core_stride, core_abort,
        output core_rdy, core_done, core_found, core_key
    );

endinterface

// File: rtl/lowest_hit_sel.sv
// rtl/lowest_hit_sel.sv - priority encoder returning the lowest set bit of a hit vector
module lowest_hit_sel #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     hits,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/crack_dispatch.sv
// rtl/crack_dispatch.sv - launches NCORES interleaved crack cores, latches the first key found
module crack_dispatch
    import crack_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int KEY_W  = KEY_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    output logic             key_valid,
    output logic [KEY_W-1:0] key,
    crack_dispatch_if.master cif
);

    localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;

    dispatch_state_t   state;
    dispatch_state_t   state_next;
    logic [NCORES-1:0] done_mask;
    logic [NCORES-1:0] hits;
    logic              all_done;
    logic              sel_hit;
    logic [IDX_W-1:0]  sel_idx;
    logic              abort_q;

    // A core that already reported this run cannot report a second hit.
    assign hits     = cif.core_done & cif.core_found & ~done_mask;
    assign all_done = &(done_mask | cif.core_done);

    lowest_hit_sel #(
        .N     (NCORES),
        .IDX_W (IDX_W)
    ) u_sel (
        .hits (hits),
        .hit  (sel_hit),
        .idx  (sel_idx)
    );

    for (genvar g = 0; g < NCORES; g++) begin : g_start
        assign cif.core_start[g*KEY_W +: KEY_W] = KEY_W'(g);
    end
    assign cif.core_stride = KEY_W'(NCORES);
    assign cif.core_abort  = abort_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        rdy         = 1'b0;
        cif.core_en = '0;
        case (state)
            S_IDLE: begin
                rdy = 1'b1;
                if (en) state_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (&cif.core_rdy) begin
                    cif.core_en = '1;
                    state_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (all_done) state_next = S_FINISH;
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key       <= '0;
            done_mask <= '0;
            abort_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        key_valid <= 1'b0;
                        key       <= '0;
                        done_mask <= '0;
                    end
                end
                S_WAIT: begin
                    done_mask <= done_mask | cif.core_done;
                    if (sel_hit && !key_valid) begin
                        key_valid <= 1'b1;
                        key       <= cif.core_key[int'(sel_idx)*KEY_W +: KEY_W];
                        abort_q   <= 1'b1;
                    end
                end
                S_FINISH: begin
                    abort_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crack_dispatch.sv
// tb/tb_crack_dispatch.sv - self-checking bench for crack_dispatch at NCORES=2 and NCORES=4
module tb_crack_dispatch;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] en;
    logic [1:0] rdy;
    logic [1:0] kv;
    logic [23:0] key_o [2];
    logic [15:0] cen [2];
    logic [1:0] abort;

    logic [15:0] b_rdy   [2];
    logic [15:0] b_done  [2];
    logic [15:0] b_found [2];
    logic [23:0] b_key   [2][16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crack_dispatch_if #(.NCORES(2), .KEY_W(24)) i2 ();
    crack_dispatch_if #(.NCORES(4), .KEY_W(24)) i4 ();

    assign i2.core_rdy   = b_rdy[0][1:0];
    assign i2.core_done  = b_done[0][1:0];
    assign i2.core_found = b_found[0][1:0];
    assign i2.core_key   = {b_key[0][1], b_key[0][0]};
    assign i4.core_rdy   = b_rdy[1][3:0];
    assign i4.core_done  = b_done[1][3:0];
    assign i4.core_found = b_found[1][3:0];
    assign i4.core_key   = {b_key[1][3], b_key[1][2], b_key[1][1], b_key[1][0]};

    assign cen[0]   = {14'b0, i2.core_en};
    assign cen[1]   = {12'b0, i4.core_en};
    assign abort[0] = i2.core_abort;
    assign abort[1] = i4.core_abort;

    crack_dispatch #(.NCORES(2), .KEY_W(24)) u2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en[0]),
        .rdy       (rdy[0]),
        .key_valid (kv[0]),
        .key       (key_o[0]),
        .cif       (i2)
    );

    crack_dispatch #(.NCORES(4), .KEY_W(24)) u4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en[1]),
        .rdy       (rdy[1]),
        .key_valid (kv[1]),
        .key       (key_o[1]),
        .cif       (i4)
    );

    // Run bookkeeping: busy from accepted en until back to ready; launched once all cores started.
    typedef struct packed {
        bit        busy;
        bit        launched;
        bit        closing;
        bit        kv;
        bit        abort;
        bit [15:0] seen;
        bit [23:0] key;
    } mdl_t;

    mdl_t m [2];

    function automatic bit [15:0] all_of(input int k);
        return (k == 0) ? 16'h0003 : 16'h000F;
    endfunction

    function automatic mdl_t step(input mdl_t cur, input int k);
        mdl_t      r   = cur;
        bit [15:0] all = all_of(k);
        bit [15:0] fresh;
        bit        got = 1'b0;
        if (!cur.busy) begin
            if (en[k]) begin
                r.busy = 1'b1; r.launched = 1'b0; r.closing = 1'b0;
                r.seen = '0;   r.kv = 1'b0;       r.key = '0;
            end
        end else if (cur.closing) begin
            r.busy = 1'b0; r.closing = 1'b0; r.abort = 1'b0;
        end else if (!cur.launched) begin
            if ((b_rdy[k] & all) == all) r.launched = 1'b1;
        end else begin
            fresh = b_done[k] & b_found[k] & ~cur.seen & all;
            for (int i = 0; i < 16; i++) begin
                if (fresh[i] && !cur.kv && !got) begin
                    got = 1'b1; r.kv = 1'b1; r.abort = 1'b1; r.key = b_key[k][i];
                end
            end
            r.seen = cur.seen | (b_done[k] & all);
            if (r.seen == all) r.closing = 1'b1;
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m[0] <= '0;
            m[1] <= '0;
        end else begin
            m[0] <= step(m[0], 0);
            m[1] <= step(m[1], 1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            automatic bit [15:0] all = all_of(k);
            automatic bit [15:0] ecen =
                (m[k].busy && !m[k].launched && ((b_rdy[k] & all) == all)) ? all : 16'h0;
            chk($sformatf("cyc_rdy%0d", k),   32'(rdy[k]),   32'(!m[k].busy));
            chk($sformatf("cyc_kv%0d", k),    32'(kv[k]),    32'(m[k].kv));
            chk($sformatf("cyc_key%0d", k),   32'(key_o[k]), 32'(m[k].key));
            chk($sformatf("cyc_abort%0d", k), 32'(abort[k]), 32'(m[k].abort));
            chk($sformatf("cyc_cen%0d", k),   32'(cen[k]),   32'(ecen));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k, input logic [15:0] d, input logic [15:0] f);
        b_done[k]  = d;
        b_found[k] = f;
        tick();
        b_done[k]  = '0;
        b_found[k] = '0;
    endtask

    task automatic wait_rdy(input int k, input int budget);
        int c = 0;
        while (!rdy[k] && c < budget) begin
            tick();
            c++;
        end
        chk($sformatf("rdy_returns%0d", k), 32'(rdy[k]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic ab;
        rst_n = 1'b1;
        en    = '0;
        for (int k = 0; k < 2; k++) begin
            b_rdy[k] = '1; b_done[k] = '0; b_found[k] = '0;
            for (int i = 0; i < 16; i++) b_key[k][i] = '0;
        end

        // Reset held with en asserted
        #1 rst_n = 1'b0; en = 2'b11;
        #10;
        for (int k = 0; k < 2; k++) begin
            chk("rst_rdy", 32'(rdy[k]), 32'd1);
            chk("rst_kv",  32'(kv[k]),  32'd0);
            chk("rst_key", 32'(key_o[k]), 32'd0);
            chk("rst_cen", 32'(cen[k]), 32'd0);
        end
        en = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("start4_3",  32'(i4.core_start[3*24 +: 24]), 32'd3);
        chk("start2_1",  32'(i2.core_start[1*24 +: 24]), 32'd1);
        chk("stride4",   32'(i4.core_stride), 32'd4);
        chk("stride2",   32'(i2.core_stride), 32'd2);

        // NCORES=2 single hit from core 1, then core 0 exhausts
        en[0] = 1'b1; tick(); en[0] = 1'b0;
        chk("t2_rdy_low", 32'(rdy[0]), 32'd0);
        chk("t2_cen",     32'(cen[0]), 32'h3);
        tick();
        repeat (3) tick();
        b_key[0][1] = 24'h000123;
        pulse(0, 16'h2, 16'h2);
        chk("t2_key",   32'(key_o[0]), 32'h000123);
        chk("t2_kv",    32'(kv[0]),    32'd1);
        chk("t2_abort", 32'(abort[0]), 32'd1);
        repeat (4) tick();
        pulse(0, 16'h1, 16'h0);
        chk("t2_fin_rdy",   32'(rdy[0]),   32'd0);
        chk("t2_fin_abort", 32'(abort[0]), 32'd1);
        tick();
        chk("t2_rdy",     32'(rdy[0]),   32'd1);
        chk("t2_abort_0", 32'(abort[0]), 32'd0);
        chk("t2_key_hold", 32'(key_o[0]), 32'h000123);

        // NCORES=4 simultaneous hits on cores 2 and 3, later hits ignored
        en[1] = 1'b1; tick(); en[1] = 1'b0;
        chk("t3_cen", 32'(cen[1]), 32'hF);
        tick();
        b_key[1][2] = 24'h0000AA;
        b_key[1][3] = 24'h0000BB;
        pulse(1, 16'hC, 16'hC);
        chk("t3_key", 32'(key_o[1]), 32'h0000AA);
        b_key[1][0] = 24'h000010;
        pulse(1, 16'h1, 16'h1);
        chk("t3_key_late", 32'(key_o[1]), 32'h0000AA);
        b_key[1][2] = 24'h0000CC;
        pulse(1, 16'h4, 16'h4);
        chk("t3_key_dup", 32'(key_o[1]), 32'h0000AA);
        pulse(1, 16'h2, 16'h0);
        chk("t3_fin_rdy", 32'(rdy[1]), 32'd0);
        tick();
        chk("t3_rdy", 32'(rdy[1]), 32'd1);

        // Exhaustion on NCORES=4
        ab = 1'b0;
        en[1] = 1'b1; tick(); en[1] = 1'b0; ab |= abort[1];
        tick(); ab |= abort[1];
        pulse(1, 16'h1, 16'h0); ab |= abort[1];
        pulse(1, 16'h6, 16'h0); ab |= abort[1];
        tick(); ab |= abort[1];
        pulse(1, 16'h8, 16'h0); ab |= abort[1];
        wait_rdy(1, 10);
        chk("t4_kv",    32'(kv[1]),    32'd0);
        chk("t4_key",   32'(key_o[1]), 32'd0);
        chk("t4_abort", 32'(ab),       32'd0);

        // Launch stall on NCORES=2, en during WAIT ignored
        b_rdy[0] = 16'h2;
        en[0] = 1'b1; tick(); en[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_cen", 32'(cen[0]), 32'd0);
            tick();
        end
        b_rdy[0] = 16'h3;
        #1;
        chk("t5_cen_pulse", 32'(cen[0]), 32'h3);
        tick();
        chk("t5_cen_off", 32'(cen[0]), 32'd0);
        en[0] = 1'b1; tick(); en[0] = 1'b0;
        chk("t5_en_ignored", 32'(rdy[0]), 32'd0);
        chk("t5_cen_quiet",  32'(cen[0]), 32'd0);
        b_key[0][0] = 24'h000055;
        pulse(0, 16'h3, 16'h1);
        chk("t5_key",     32'(key_o[0]), 32'h000055);
        chk("t5_fin_rdy", 32'(rdy[0]),   32'd0);
        wait_rdy(0, 10);

        // Mid-run reset with abort high, concurrent core pulse dropped
        en[0] = 1'b1; tick(); en[0] = 1'b0;
        tick();
        b_key[0][0] = 24'h000077;
        pulse(0, 16'h1, 16'h1);
        chk("t6_abort", 32'(abort[0]), 32'd1);
        tick();
        #3;
        b_done[0] = 16'h2;
        rst_n = 1'b0;
        #1;
        chk("t6_rdy",   32'(rdy[0]),   32'd1);
        chk("t6_kv",    32'(kv[0]),    32'd0);
        chk("t6_key",   32'(key_o[0]), 32'd0);
        chk("t6_abort0", 32'(abort[0]), 32'd0);
        chk("t6_cen",   32'(cen[0]),   32'd0);
        b_done[0] = '0;
        tick();
        rst_n = 1'b1;
        tick();
        en[0] = 1'b1; tick(); en[0] = 1'b0;
        chk("t6_new_cen", 32'(cen[0]), 32'h3);
        tick();
        pulse(0, 16'h3, 16'h0);
        wait_rdy(0, 10);
        chk("t6_new_kv", 32'(kv[0]), 32'd0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crack_dispatch.md
# crack_dispatch

Parametrised N-core ARC4 key-search dispatcher, the generalisation of the two-core parallel cracker to any core count. It accepts a single start request, launches `NCORES` crack cores on interleaved slices of the key space, and latches the first key reported as valid. It then aborts the remaining cores and returns to ready once every core has reported completion. It sits between the top-level control (KEY/SW/HEX glue) and the array of crack cores, which share the ciphertext memory arrangement.

## Interface
- `NCORES`, default 2: number of crack cores; 1 to 16.
- `KEY_W`, default 24: key width in bits.
- `clk` in, 1: system clock (CLOCK_50 at top level).
- `rst_n` in, 1: asynchronous, active-low reset.
- `en` in, 1: start request; sampled only while `rdy`=1.
- `rdy` out, 1: 1 in IDLE only.
- `key_valid` out, 1: a key was found in the last run.
- `key` out, KEY_W: found key; 0 when not found.
- `core_en` out, NCORES: one-cycle launch pulse per core.
- `core_rdy` in, NCORES: per-core ready.
- `core_start` out, NCORES*KEY_W: slice i = i, the first key for core i.
- `core_stride` out, KEY_W: constant NCORES.
- `core_abort` out, 1: level; cores stop at their next key boundary.
- `core_done` in, NCORES: one-cycle pulse when core i finishes or aborts.
- `core_found` in, NCORES: qualifies `core_done[i]`; 1 means core i found a key.
- `core_key` in, NCORES*KEY_W: core i's key, valid with its `core_done`.

## Operation
- Reset values: state IDLE, `rdy`=1, `key_valid`=0, `key`=0, `core_en`=0, `core_abort`=0, done_mask=0.
- States are IDLE, LAUNCH, WAIT and FINISH.
- IDLE: when `en`=1, go to LAUNCH. On entry to LAUNCH, clear `key_valid`, `key` and done_mask.
- LAUNCH: hold until `core_rdy` is all ones. Then drive `core_en`=all ones for exactly one cycle and go to WAIT.
- WAIT:
  - Each cycle, OR `core_done` into done_mask.
  - If any done core has `core_found`=1 and `key_valid`=0, latch `key` from the lowest such index. Set `key_valid`=1 and `core_abort`=1.
  - Found reports after the first are ignored; the first key wins.
  - Simultaneous hits resolve to the lowest core index.
  - A `core_done` on a core already in done_mask is ignored; a core reports only once per run.
- When done_mask is all ones (including the cycle where the final pulse is merged), go to FINISH.
- FINISH: deassert `core_abort`. Go to IDLE; `rdy`=1 on the following cycle.
- The search is exhausted with no hit when all cores report done with found=0. In that case `key_valid`=0 and `key`=0.
- `key` and `key_valid` hold their values through IDLE until the next accepted `en`.
- `en` outside IDLE is ignored.
- Reset asserted mid-run returns to reset values immediately. Any core pulse arriving in the same cycle is dropped.

## Timing
- `en` high at edge t (IDLE): `rdy`=0 from t+1.
- If `core_rdy` is all ones, `core_en` is high during cycle t+1 only, and the state is WAIT from t+2.
- `core_found`/`core_done` at edge d: `key`, `key_valid` and `core_abort` update at d+1.
- Last `core_done` at edge d: FINISH at d+1, `rdy`=1 at d+2.
- Minimum run length is therefore 4 cycles.

## Structure
- `crack_pkg` holds the state enum `dispatch_state_t`, `KEY_W_DEFAULT`=24, and the core-count bound.
- One sub-module, `lowest_hit_sel`: a parametrised priority encoder. It takes `core_done & core_found` and returns a hit flag plus a `$clog2(NCORES)` index used to mux `core_key`.
- `core_start`/`core_stride` are constants generated in a loop.

## Test plan
- **Reset:** hold `rst_n`=0 for 10 ps with `en`=1.
  - Required: `rdy`=1, `key_valid`=0, `key`=0, `core_en`=0.
- **NCORES=2, single hit:** core 1 pulses done/found with key 0x000123 at cycle 40; core 0 pulses done/found=0 at 45.
  - Required: `key`=0x000123 and `key_valid`=1 at 41; `core_abort` high 41 to FINISH; `rdy`=1 two cycles after 45.
- **NCORES=4, simultaneous hits:** cores 2 and 3 report keys 0x0000AA and 0x0000BB in the same cycle.
  - Required: `key`=0x0000AA.
  - A later hit from core 0 with 0x000010 leaves `key` unchanged.
- **Exhaustion:** all cores report found=0.
  - Required: `key_valid`=0, `key`=0, `core_abort` never asserted, `rdy` returns.
- **Launch stall:** `core_rdy`=0b10 for 5 cycles after `en`.
  - Required: `core_en` stays 0 until `core_rdy`=0b11, then a single one-cycle pulse of 0b11.
  - A second `en` during WAIT is ignored.
- **Mid-run reset:** assert `rst_n`=0 during WAIT with `core_abort`=1.
  - Required: all outputs return to reset values asynchronously, and a new `en` starts a clean run.
